// File: rtl/ps2_scancode_rx_if.sv
// PS/2 receiver bundle: raw connector lines in, folded key code and strobes out.
interface ps2_scancode_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [9:0] data;
  logic       ready;
  logic       frame_err;

  modport master (output ps2_clk, ps2_data, input data, ready, frame_err);
  modport slave  (input ps2_clk, ps2_data, output data, ready, frame_err);
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver; folds E0/F0 prefixes into {ext, brk, scan}.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            rst,
  ps2_scancode_rx_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [9:0]    data_q, data_d;
  logic          ready_q, ready_d, err_q, err_d;
  logic          fall;

  always_comb begin
    state_d    = state_q;
    clk_s1_d   = bus.ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = bus.ps2_data;
    dat_s2_d   = dat_s1_q;
    filt_d     = filt_q;
    filt_cnt_d = '0;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    data_d     = data_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;

    // Level flips only after FILTER_LEN consecutive disagreeing samples
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                                   filt_cnt_d = filt_cnt_q + 1'b1;
    end
    fall = filt_q & ~filt_d;

    to_cnt_d = (state_q == IDLE || fall) ? '0 : to_cnt_q + 1'b1;

    case (state_q)
      IDLE: if (fall && !dat_s2_q) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (fall) begin
        shift_d   = {dat_s2_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        par_d   = dat_s2_q;
        state_d = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        if (dat_s2_q && ^{shift_q, par_q}) begin
          if (shift_q == 8'hE0)      ext_d = 1'b1;
          else if (shift_q == 8'hF0) brk_d = 1'b1;
          else begin
            data_d  = {ext_q, brk_q, shift_q};
            ready_d = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
          end
        end else begin
          err_d = 1'b1;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Stalled partial frame: drop it and any pending prefixes silently
    if (state_q != IDLE && !fall && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d  = IDLE;
      ext_d    = 1'b0;
      brk_d    = 1'b0;
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      to_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      to_cnt_q   <= to_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.ready     = ready_q;
  assign bus.frame_err = err_q;
endmodule
